// File: rtl/fryer_pkg.sv
// Shared fryer controller definitions: state encoding, BCD limit, timing defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fryer_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } cook_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // One unit is one minute at 1 kHz; the buzzer sounds for three seconds.
    localparam int TICKS_PER_UNIT_DEF = 60000;
    localparam int BUZZ_CYCLES_DEF    = 3000;

    // Single BCD digit increment, wrapping 9 -> 0 with no carry out.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/cook_tick_gen.sv
// Prescaler: counts 0..TICKS_PER_UNIT-1 and pulses tick on the wrapping cycle.
// Latency: tick is combinational from the registered count (same cycle as the wrap).
// Backpressure: hold freezes the count; clr wins over run and hold.
module cook_tick_gen
    import fryer_pkg::*;
#(
    parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF
) (
    input  logic clk_1Khz,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int CW = $clog2(TICKS_PER_UNIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICKS_PER_UNIT - 1);

    logic [CW-1:0] cnt;
    logic          adv;

    assign adv  = run && !hold && !clr;
    assign tick = adv && (cnt == CNT_MAX);

    // Free-running modulo counter, advanced only while running and not frozen.
    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cook_timer.sv
// Fryer countdown: two-digit BCD cook time set by key pulses, counted down while running.
// Latency: all outputs registered; a pulse sampled at edge N shows after edge N.
// Backpressure: none; pulses outside their accepting state are dropped.
module cook_timer
    import fryer_pkg::*;
#(
    parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
    parameter int BUZZ_CYCLES    = BUZZ_CYCLES_DEF
) (
    input  logic       clk_1Khz,
    input  logic       rst,
    input  logic       enable,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       inc_tens,
    input  logic       inc_ones,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       buzz
);

    localparam int BW = $clog2(BUZZ_CYCLES + 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);

    cook_state_t state;
    logic [BW-1:0] buzz_cnt;

    logic       time_zero;
    logic       start_go;
    logic       resume;
    logic       tick_clr;
    logic       tick_run;
    logic       tick_hold;
    logic       tick;
    logic [3:0] dec_tens;
    logic [3:0] dec_ones;
    logic       dec_zero;

    assign time_zero = (time_tens == 4'd0) && (time_ones == 4'd0);
    assign start_go  = (state == ST_IDLE) && start && !time_zero;
    assign resume    = (state == ST_PAUSE) && (start || pause);

    // The prescaler restarts on power loss, abort, or a fresh start; it only
    // advances in RUN (not on the pausing cycle) and on the resuming cycle.
    assign tick_clr  = !enable || clear || start_go;
    assign tick_run  = (state == ST_RUN) || (state == ST_PAUSE);
    assign tick_hold = ((state == ST_RUN) && pause) || ((state == ST_PAUSE) && !resume);

    cook_tick_gen #(
        .TICKS_PER_UNIT (TICKS_PER_UNIT)
    ) u_tick_gen (
        .clk_1Khz (clk_1Khz),
        .rst      (rst),
        .clr      (tick_clr),
        .run      (tick_run),
        .hold     (tick_hold),
        .tick     (tick)
    );

    // BCD decrement with borrow from tens when ones is 0.
    always_comb begin
        dec_tens = time_tens;
        dec_ones = time_ones - 4'd1;
        if (time_ones == 4'd0) begin
            dec_ones = BCD_MAX;
            dec_tens = time_tens - 4'd1;
        end
        dec_zero = (time_tens == 4'd0) && (time_ones == 4'd1);
    end

    // Main FSM with digit registers, buzzer counter and registered status outputs.
    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            state     <= ST_OFF;
            time_tens <= 4'd0;
            time_ones <= 4'd0;
            running   <= 1'b0;
            paused    <= 1'b0;
            done      <= 1'b0;
            buzz      <= 1'b0;
            buzz_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (!enable) begin
                state     <= ST_OFF;
                time_tens <= 4'd0;
                time_ones <= 4'd0;
                running   <= 1'b0;
                paused    <= 1'b0;
                buzz      <= 1'b0;
                buzz_cnt  <= '0;
            end else if (clear && (state != ST_OFF)) begin
                state     <= ST_IDLE;
                time_tens <= 4'd0;
                time_ones <= 4'd0;
                running   <= 1'b0;
                paused    <= 1'b0;
                buzz      <= 1'b0;
                buzz_cnt  <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (start_go) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end else begin
                            if (inc_tens) time_tens <= bcd_inc(time_tens);
                            if (inc_ones) time_ones <= bcd_inc(time_ones);
                        end
                    end
                    ST_RUN, ST_PAUSE: begin
                        if (state == ST_RUN && pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end else if (resume) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                            paused  <= 1'b0;
                        end
                        // A tick can only occur in RUN or on the resuming cycle.
                        if (tick) begin
                            time_tens <= dec_tens;
                            time_ones <= dec_ones;
                            if (dec_zero) begin
                                state    <= ST_DONE;
                                running  <= 1'b0;
                                paused   <= 1'b0;
                                done     <= 1'b1;
                                buzz     <= 1'b1;
                                buzz_cnt <= '0;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (buzz_cnt == BUZZ_LAST) begin
                            state     <= ST_IDLE;
                            buzz      <= 1'b0;
                            time_tens <= 4'd0;
                            time_ones <= 4'd0;
                            buzz_cnt  <= '0;
                        end else begin
                            buzz_cnt <= buzz_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with a small scoreboard of expected outputs.
// Latency: expectations are pushed before each edge and checked half a cycle after it.
// Backpressure: n/a.
module tb_cook_timer;

    logic       clk_1Khz = 1'b0;
    logic       rst      = 1'b0;
    logic       enable   = 1'b1;
    logic       start    = 1'b0;
    logic       pause    = 1'b0;
    logic       clear    = 1'b0;
    logic       inc_tens = 1'b0;
    logic       inc_ones = 1'b0;
    logic [3:0] time_tens;
    logic [3:0] time_ones;
    logic       running;
    logic       paused;
    logic       done;
    logic       buzz;

    int checks = 0;
    int errors = 0;

    string       tag_q[$];
    logic [11:0] exp_q[$];

    cook_timer #(
        .TICKS_PER_UNIT (4),
        .BUZZ_CYCLES    (3)
    ) dut (
        .clk_1Khz  (clk_1Khz),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .inc_tens  (inc_tens),
        .inc_ones  (inc_ones),
        .time_tens (time_tens),
        .time_ones (time_ones),
        .running   (running),
        .paused    (paused),
        .done      (done),
        .buzz      (buzz)
    );

    always #5 clk_1Khz = ~clk_1Khz;

    task automatic push_exp(input string tag, input int t, input int o,
                            input bit r, input bit p, input bit d, input bit b);
        tag_q.push_back(tag);
        exp_q.push_back({t[3:0], o[3:0], r, p, d, b});
    endtask

    task automatic pop_check();
        logic [11:0] obs;
        logic [11:0] expv;
        string       tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: observed empty queue, required an entry");
        end else begin
            tag  = tag_q.pop_front();
            expv = exp_q.pop_front();
            obs  = {time_tens, time_ones, running, paused, done, buzz};
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s: observed tens=%0d ones=%0d run=%b pau=%b done=%b buzz=%b, expected tens=%0d ones=%0d run=%b pau=%b done=%b buzz=%b",
                       tag, obs[11:8], obs[7:4], obs[3], obs[2], obs[1], obs[0],
                       expv[11:8], expv[7:4], expv[3], expv[2], expv[1], expv[0]);
            end
        end
    endtask

    // One clock edge with the currently driven inputs, then check after it.
    task automatic step(input string tag, input int t, input int o,
                        input bit r, input bit p, input bit d, input bit b);
        push_exp(tag, t, o, r, p, d, b);
        @(posedge clk_1Khz);
        @(negedge clk_1Khz);
        start    = 1'b0;
        pause    = 1'b0;
        clear    = 1'b0;
        inc_tens = 1'b0;
        inc_ones = 1'b0;
        pop_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk_1Khz);
        // Reset held with enable high; a stray key pulse is ignored.
        inc_ones = 1'b1;
        step("reset0", 0, 0, 0, 0, 0, 0);
        step("reset1", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("release", 0, 0, 0, 0, 0, 0);
        // IDLE after one edge: the very next key is accepted.
        inc_ones = 1'b1; step("inc_o1", 0, 1, 0, 0, 0, 0);
        inc_ones = 1'b1; step("inc_o2", 0, 2, 0, 0, 0, 0);
        inc_ones = 1'b1; step("inc_o3", 0, 3, 0, 0, 0, 0);
        inc_tens = 1'b1; step("set13", 1, 3, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            inc_ones = 1'b1;
            step("ones_wrap", 1, (3 + i) % 10, 0, 0, 0, 0);
        end
        clear = 1'b1; step("clear_idle", 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            inc_tens = 1'b1;
            step("tens_wrap", i % 10, 0, 0, 0, 0, 0);
        end

        // start at 00 ignored; start+inc_ones at 00 lets the inc through.
        start = 1'b1; step("start00", 0, 0, 0, 0, 0, 0);
        start = 1'b1; inc_ones = 1'b1; step("st_inc00", 0, 1, 0, 0, 0, 0);
        // At 01 the start wins and the inc is dropped; one-unit cook.
        start = 1'b1; inc_ones = 1'b1; step("st_inc01", 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("run01", 0, 1, 1, 0, 0, 0);
        step("done01", 0, 0, 0, 0, 1, 1);
        step("buzz1", 0, 0, 0, 0, 0, 1);
        step("buzz2", 0, 0, 0, 0, 0, 1);
        step("buzz_end", 0, 0, 0, 0, 0, 0);
        inc_ones = 1'b1; step("idle_after_buzz", 0, 1, 0, 0, 0, 0);
        inc_ones = 1'b1; step("set02", 0, 2, 0, 0, 0, 0);

        // Full cook of 02 with a stray start during RUN.
        start = 1'b1; step("start02", 0, 2, 1, 0, 0, 0);
        start = 1'b1; step("start_in_run", 0, 2, 1, 0, 0, 0);
        step("run02a", 0, 2, 1, 0, 0, 0);
        step("run02b", 0, 2, 1, 0, 0, 0);
        step("dec_to01", 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("run01b", 0, 1, 1, 0, 0, 0);
        step("done02", 0, 0, 0, 0, 1, 1);
        clear = 1'b1; step("clear_done", 0, 0, 0, 0, 0, 0);
        inc_tens = 1'b1; step("set10", 1, 0, 0, 0, 0, 0);

        // Borrow from tens.
        start = 1'b1; step("start10", 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("run10", 1, 0, 1, 0, 0, 0);
        step("borrow09", 0, 9, 1, 0, 0, 0);

        // Power switch dropped mid-RUN.
        enable = 1'b0; step("en_off", 0, 0, 0, 0, 0, 0);
        start = 1'b1; inc_ones = 1'b1; step("en_off_keys", 0, 0, 0, 0, 0, 0);
        enable = 1'b1; inc_ones = 1'b1; step("off_to_idle", 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            inc_ones = 1'b1;
            step("set05", 0, i, 0, 0, 0, 0);
        end

        // Pause with prescaler at 1, hold 20 cycles, resume with pause.
        start = 1'b1; step("start05", 0, 5, 1, 0, 0, 0);
        step("run05", 0, 5, 1, 0, 0, 0);
        pause = 1'b1; step("pause", 0, 5, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step("paused_hold", 0, 5, 0, 1, 0, 0);
        pause = 1'b1; step("resume", 0, 5, 1, 0, 0, 0);
        step("resume_wait", 0, 5, 1, 0, 0, 0);
        step("resume_dec04", 0, 4, 1, 0, 0, 0);

        // Pause with prescaler at 0, resume with start.
        pause = 1'b1; step("pause2", 0, 4, 0, 1, 0, 0);
        step("paused2", 0, 4, 0, 1, 0, 0);
        start = 1'b1; step("resume_start", 0, 4, 1, 0, 0, 0);
        step("run04a", 0, 4, 1, 0, 0, 0);
        step("run04b", 0, 4, 1, 0, 0, 0);
        step("dec03", 0, 3, 1, 0, 0, 0);

        // Asynchronous reset mid-RUN clears outputs without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        push_exp("async_rst", 0, 0, 0, 0, 0, 0);
        pop_check();
        @(negedge clk_1Khz);
        step("rst_hold", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("rst_release", 0, 0, 0, 0, 0, 0);
        inc_ones = 1'b1; step("post_rst_idle", 0, 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cook_timer.md
# cook_timer

Countdown core of the fryer controller, between key debouncing and seg_counter. It takes one-cycle key pulses and the power switch, holds the two-digit BCD cooking time, and counts it down at a fixed rate while running. It drives the time digits, the run/pause status and the end-of-cook buzzer.

## Interface
- TICKS_PER_UNIT, 60000: clk_1Khz cycles per decrement (1 min); benches override to small values.
- BUZZ_CYCLES, 3000: cycles buzz stays high after completion.
- clk_1Khz  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  power switch (SW3 level); low forces OFF.
- start  in  1  one-cycle pulse: start/resume.
- pause  in  1  one-cycle pulse: pause/resume toggle.
- clear  in  1  one-cycle pulse: abort, time to 00.
- inc_tens  in  1  one-cycle pulse: tens digit +1.
- inc_ones  in  1  one-cycle pulse: ones digit +1.
- time_tens  out  4  BCD tens digit.
- time_ones  out  4  BCD ones digit.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  one-cycle pulse on reaching 00.
- buzz  out  1  buzzer enable.

## Operation
- States: OFF, IDLE, RUN, PAUSE, DONE. Reset -> OFF. All outputs are 0 in reset and OFF.
- Priority per cycle: enable low > clear > start/pause > inc_*.
- enable low, from any state: go to OFF. Digits, prescaler and buzz clear. All pulses are ignored.
- OFF with enable high: go to IDLE next cycle. Pulses in that cycle are ignored.
- clear, in any state except OFF: go to IDLE. Digits 00, prescaler 0, buzz 0.
- IDLE, inc_tens: tens 0..9; 9 wraps to 0. inc_ones works the same on ones. The ones digit never carries into tens. Both in the same cycle: each digit steps.
- IDLE, start: go to RUN if time != 00 and reset the prescaler. If time == 00, start is ignored. pause is ignored in IDLE.
- RUN: the prescaler counts 0..TICKS_PER_UNIT-1. When it reaches TICKS_PER_UNIT-1 it returns to 0 and time decrements in BCD. Ones 0 borrows: ones becomes 9 and tens decrements.
- RUN, the decrement that yields 00: go to DONE, done=1 for that cycle, buzz=1.
- RUN, pause: go to PAUSE. The prescaler freezes and no decrement happens that cycle. start is ignored in RUN. inc_* are ignored outside IDLE.
- PAUSE, start or pause: go back to RUN. The prescaler resumes from its frozen value.
- DONE: buzz stays high for exactly BUZZ_CYCLES cycles, then the state is IDLE with buzz 0 and time 00. start and pause are ignored in DONE.
- running is high only in RUN, paused only in PAUSE.

## Timing
- All outputs are registered. A pulse sampled at edge N is visible after edge N.
- Start accepted at edge S: the first decrement occurs at edge S+TICKS_PER_UNIT. A cook of value T ends at edge S+T·TICKS_PER_UNIT.
- done and the entry into DONE happen at the same edge. buzz rises at that edge. The state becomes IDLE BUSS_CYCLES edges later.
- Pause at edge P with prescaler value k: the remaining interval after resume is TICKS_PER_UNIT-1-k cycles plus the resume edge.
- Asynchronous reset mid-RUN clears everything immediately. Release is synchronous to clk_1Khz, and the block comes up in OFF.

## Structure
- Shared package fryer_pkg holds:
  - the state encoding constants (OFF/IDLE/RUN/PAUSE/DONE);
  - BCD_MAX=9;
  - defaults for TICKS_PER_UNIT and BUZZ_CYCLES, also used by state_control.
- One sub-module, cook_tick_gen: the prescaler with run/hold/clear inputs and a one-cycle tick output. The BCD digits, the FSM and the buzz counter stay in cook_timer.

## Test plan
All scenarios use TICKS_PER_UNIT=4 and BUZZ_CYCLES=3.
- Power and reset:
  - rst low, enable=1 -> all outputs 0, state OFF.
  - Release rst -> IDLE after one edge.
  - Drop enable mid-RUN -> outputs 0 on the next edge.
- Setting:
  - 3×inc_ones, 1×inc_tens -> 13.
  - 7 more inc_ones -> 10 (wraps, no carry).
  - 10×inc_tens from 0 -> tens 0.
- Full cook:
  - Set 02, start -> 01 at +4 edges.
  - 00 at +8 edges with done=1 for one cycle.
  - buzz high for 3 cycles, then IDLE.
- Borrow: set 10, start -> 09 after 4 edges, running=1.
- Pause and resume:
  - Set 05, start, pause after 2 edges -> paused=1, digits stay 05 for 20 cycles.
  - pause again -> 04 exactly 2 edges later.
- Edge cases:
  - start at 00 -> stays IDLE.
  - start+inc_ones in the same IDLE cycle -> ones increments only if start was ignored (time 00).
  - clear during DONE -> buzz 0, IDLE next edge.
  - start during RUN -> no effect.
